// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: operands are latched on start and summed LSB-first through
// one full-adder cell and a carry flop. A one-cycle done pulse marks s/cout valid.
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic sumBit;
  logic carryNext;
  logic lastBit;

  // Single full-adder cell working on the current LSBs and the stored carry
  always_comb begin
    sumBit    = ra[0] ^ rb[0] ^ carry;
    carryNext = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    lastBit   = (cnt == CW'(WIDTH - 1));
  end

  // State register; reset returns to IDLE from anywhere, discarding partial work
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (lastBit) begin
          nextState = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath: latch operands, shift one bit per cycle, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          ra    <= {1'b0, ra[WIDTH-1:1]};
          rb    <= {1'b0, rb[WIDTH-1:1]};
          acc   <= {sumBit, acc[WIDTH-1:1]};
          carry <= carryNext;
          cnt   <= cnt + 1'b1;
          if (lastBit) begin
            s    <= {sumBit, acc[WIDTH-1:1]};
            cout <= carryNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
